// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one backing-memory port between the I-cache line refill
//            path (multi-beat bursts) and the data-memory path (single-word
//            loads/stores). Emits the ic_repl_permit_o strobe once a full
//            line has been delivered.
// Ports    : clk_i, reset_i          - clock, synchronous active-high reset
//            ic_req_i/ic_addr_i      - refill request and miss address
//            ic_rvalid_o/ic_rdata_o  - refill beat strobe and data
//            ic_beat_o               - word index of the current beat
//            ic_repl_permit_o        - line complete, replacement may commit
//            dm_req_i/dm_we_i/...    - data access request fields
//            dm_done_o/dm_rdata_o    - data completion strobe and load data
//            mem_*                   - shared backing-memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           ic_req_i,
  input  logic [31:0]                    ic_addr_i,
  output logic                           ic_rvalid_o,
  output logic [31:0]                    ic_rdata_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] ic_beat_o,
  output logic                           ic_repl_permit_o,
  input  logic                           dm_req_i,
  input  logic                           dm_we_i,
  input  logic [31:0]                    dm_addr_i,
  input  logic [31:0]                    dm_wdata_i,
  input  logic [3:0]                     dm_byte_en_i,
  output logic                           dm_done_o,
  output logic [31:0]                    dm_rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [31:0]                    mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  output logic [3:0]                     mem_byte_en_o,
  input  logic                           mem_ack_i,
  input  logic [31:0]                    mem_rdata_i
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  // Clears the word and byte offset bits of a line address.
  localparam logic [31:0] C_LINE_MASK = ~(32'(BLOCK_WORDS * 4) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IC_BURST  = 3'd1,
    S_DM_ACCESS = 3'd2,
    S_IC_RESP   = 3'd3,
    S_DM_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_beat;
  logic             r_last_ic;   // 1: the I side received the most recent grant
  logic [31:0]      r_ic_base;
  logic [31:0]      r_dm_addr;
  logic [31:0]      r_dm_wdata;
  logic [31:0]      r_dm_rdata;
  logic             r_dm_we;
  logic [3:0]       r_dm_be;

  logic             w_grant_dm;
  logic             w_grant_ic;
  logic             w_last_beat;
  logic [31:0]      w_beat_off;

  // On a tie, the side that did not win last time gets the port.
  assign w_grant_dm  = dm_req_i & (~ic_req_i | r_last_ic);
  assign w_grant_ic  = ic_req_i & (~dm_req_i | ~r_last_ic);
  assign w_last_beat = (r_beat == OFF_W'(BLOCK_WORDS - 1));
  assign w_beat_off  = {{(30 - OFF_W){1'b0}}, r_beat, 2'b00};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_last_ic  <= 1'b1;
      r_ic_base  <= '0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_dm_rdata <= '0;
      r_dm_we    <= 1'b0;
      r_dm_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_state    <= S_DM_ACCESS;
            r_last_ic  <= 1'b0;
            r_dm_addr  <= dm_addr_i & 32'hFFFF_FFFC;
            r_dm_we    <= dm_we_i;
            r_dm_wdata <= dm_wdata_i;
            r_dm_be    <= dm_byte_en_i;
          end else if (w_grant_ic) begin
            r_state   <= S_IC_BURST;
            r_last_ic <= 1'b1;
            r_ic_base <= ic_addr_i & C_LINE_MASK;
            r_beat    <= '0;
          end
        end
        S_IC_BURST: begin
          if (mem_ack_i) begin
            // Power-of-two line size lets the counter wrap to 0 by itself.
            r_beat <= r_beat + OFF_W'(1);
            if (w_last_beat) begin
              r_state <= S_IC_RESP;
            end
          end
        end
        S_DM_ACCESS: begin
          if (mem_ack_i) begin
            // Stores leave the last load result untouched.
            if (!r_dm_we) begin
              r_dm_rdata <= mem_rdata_i;
            end
            r_state <= S_DM_RESP;
          end
        end
        S_IC_RESP: r_state <= S_IDLE;
        S_DM_RESP: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ic_rvalid_o      = 1'b0;
    ic_rdata_o       = '0;
    ic_beat_o        = '0;
    ic_repl_permit_o = 1'b0;
    dm_done_o        = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_byte_en_o    = '0;
    case (r_state)
      S_IC_BURST: begin
        mem_req_o     = 1'b1;
        mem_addr_o    = r_ic_base + w_beat_off;
        mem_byte_en_o = 4'hF;
        ic_rvalid_o   = mem_ack_i;
        ic_rdata_o    = mem_rdata_i;
        ic_beat_o     = r_beat;
      end
      S_DM_ACCESS: begin
        mem_req_o     = 1'b1;
        mem_we_o      = r_dm_we;
        mem_addr_o    = r_dm_addr;
        mem_wdata_o   = r_dm_wdata;
        mem_byte_en_o = r_dm_we ? r_dm_be : 4'hF;
      end
      S_IC_RESP: ic_repl_permit_o = 1'b1;
      S_DM_RESP: dm_done_o        = 1'b1;
      default: ;
    endcase
  end

  assign dm_rdata_o = r_dm_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (BLOCK_WORDS = 4).
//            Expected beat addresses and load data are queued when stimulus
//            is issued and popped when the arbiter produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int BW = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic        ic_rvalid_o;
  logic [31:0] ic_rdata_o;
  logic [1:0]  ic_beat_o;
  logic        ic_repl_permit_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_byte_en_i;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_byte_en_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'h0;

  mem_arbiter #(.BLOCK_WORDS(BW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_beat_o(ic_beat_o),
    .ic_repl_permit_o(ic_repl_permit_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_byte_en_i(dm_byte_en_i),
    .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_mem_be"}, 32'(mem_byte_en_o), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, "_dm_done"}, 32'(dm_done_o), 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 32'h0);
    chk({tag, "_ic_rvalid"}, 32'(ic_rvalid_o), 32'h0);
    chk({tag, "_permit"}, 32'(ic_repl_permit_o), 32'h0);
  endtask

  // Issues a data request in the current (IDLE) cycle and serves it with
  // 'waits' unacknowledged request cycles before the ack.
  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int waits, input logic [31:0] rdata);
    logic [31:0] exp_addr;
    exp_addr     = addr & 32'hFFFF_FFFC;
    dm_req_i     = 1'b1;
    dm_we_i      = we;
    dm_addr_i    = addr;
    dm_wdata_i   = wdata;
    dm_byte_en_i = be;
    if (!we) exp_q.push_back(rdata);
    cyc();
    // Fields were latched at grant; later changes must not leak through.
    dm_we_i      = ~we;
    dm_addr_i    = ~addr;
    dm_wdata_i   = ~wdata;
    dm_byte_en_i = ~be;
    for (int i = 0; i <= waits; i++) begin
      mem_ack_i   = (i == waits);
      mem_rdata_i = (i == waits) ? rdata : (32'hBAD0_0000 | 32'(i));
      #1;
      chk("dm_mem_req", 32'(mem_req_o), 32'h1);
      chk("dm_mem_addr", mem_addr_o, exp_addr);
      chk("dm_mem_we", 32'(mem_we_o), 32'(we));
      chk("dm_mem_be", 32'(mem_byte_en_o), we ? 32'(be) : 32'hF);
      if (we) chk("dm_mem_wdata", mem_wdata_o, wdata);
      chk("dm_done_early", 32'(dm_done_o), 32'h0);
      chk("dm_no_ic_rvalid", 32'(ic_rvalid_o), 32'h0);
      cyc();
    end
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    dm_req_i    = 1'b0;
    #1;
    chk("dm_done", 32'(dm_done_o), 32'h1);
    if (!we) last_load = exp_q.pop_front();
    chk("dm_rdata", dm_rdata_o, last_load);
    chk("dm_resp_mem_req", 32'(mem_req_o), 32'h0);
    cyc();
    chk("dm_done_one_cycle", 32'(dm_done_o), 32'h0);
    chk("dm_rdata_hold", dm_rdata_o, last_load);
    chk("dm_idle_mem_req", 32'(mem_req_o), 32'h0);
  endtask

  // Issues a refill in the current (IDLE) cycle, acks every beat, and
  // optionally raises a load request to dm_addr_mid during beat dm_beat.
  task automatic ic_burst(input logic [31:0] addr, input int dm_beat, input logic [31:0] dm_addr_mid);
    logic [31:0] base;
    base      = addr & 32'hFFFF_FFF0;
    ic_req_i  = 1'b1;
    ic_addr_i = addr;
    for (int i = 0; i < BW; i++) exp_q.push_back(base + 32'(4 * i));
    cyc();
    ic_addr_i = 32'hFFFF_FFFF;
    for (int i = 0; i < BW; i++) begin
      if (i == dm_beat) begin
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = dm_addr_mid;
      end
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hC0DE_0000 + 32'(i);
      #1;
      chk("ic_mem_addr", mem_addr_o, exp_q.pop_front());
      chk("ic_mem_req", 32'(mem_req_o), 32'h1);
      chk("ic_mem_we", 32'(mem_we_o), 32'h0);
      chk("ic_rvalid", 32'(ic_rvalid_o), 32'h1);
      chk("ic_beat", 32'(ic_beat_o), 32'(i));
      chk("ic_rdata", ic_rdata_o, 32'hC0DE_0000 + 32'(i));
      chk("ic_no_dm_done", 32'(dm_done_o), 32'h0);
      chk("ic_permit_early", 32'(ic_repl_permit_o), 32'h0);
      cyc();
    end
    ic_req_i    = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1;
    chk("ic_permit", 32'(ic_repl_permit_o), 32'h1);
    chk("ic_resp_mem_req", 32'(mem_req_o), 32'h0);
    chk("ic_resp_rvalid", 32'(ic_rvalid_o), 32'h0);
    cyc();
    chk("ic_permit_one_cycle", 32'(ic_repl_permit_o), 32'h0);
    chk("ic_idle_mem_req", 32'(mem_req_o), 32'h0);
  endtask

  initial begin
    reset_i      = 1'b1;
    ic_req_i     = 1'b0;
    ic_addr_i    = 32'h0;
    dm_req_i     = 1'b0;
    dm_we_i      = 1'b0;
    dm_addr_i    = 32'h0;
    dm_wdata_i   = 32'h0;
    dm_byte_en_i = 4'h0;
    mem_ack_i    = 1'b0;
    mem_rdata_i  = 32'h0;
    cyc();
    cyc();
    chk_all_zero("reset");
    reset_i = 1'b0;
    cyc();

    // Load with two wait states, then a store.
    do_dm(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEAD_BEEF);
    do_dm(1'b1, 32'h0000_0204, 32'h1234_5678, 4'b0011, 0, 32'h5555_AAAA);

    // Refill of the line holding 0x1238.
    ic_burst(32'h0000_1238, -1, 32'h0);

    // Two ties in a row: D wins (last grant was I), then I wins while the
    // re-raised data request waits out the burst.
    ic_req_i = 1'b1;
    do_dm(1'b0, 32'h0000_0400, 32'h0, 4'h0, 1, 32'h0BAD_F00D);
    dm_req_i  = 1'b1;
    dm_addr_i = 32'h0000_0500;
    ic_burst(32'h0000_2000, -1, 32'h0);
    do_dm(1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 32'h1111_2222);

    // Data request raised mid-burst; unaligned address bits ignored.
    ic_burst(32'h0000_3004, 2, 32'h0000_0307);
    do_dm(1'b0, 32'h0000_0307, 32'h0, 4'h0, 0, 32'h7777_8888);

    // Reset after beat 1 of a burst.
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_4000;
    cyc();
    for (int i = 0; i < 2; i++) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hFACE_0000 + 32'(i);
      #1;
      chk("rst_burst_beat", 32'(ic_beat_o), 32'(i));
      chk("rst_burst_addr", mem_addr_o, 32'h0000_4000 + 32'(4 * i));
      cyc();
    end
    mem_ack_i = 1'b0;
    ic_req_i  = 1'b0;
    reset_i   = 1'b1;
    cyc();
    chk_all_zero("midburst_reset");
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset_no_permit", 32'(ic_repl_permit_o), 32'h0);
      chk("post_reset_idle", 32'(mem_req_o), 32'h0);
    end

    // Tie right after reset goes to D first.
    ic_req_i = 1'b1;
    do_dm(1'b0, 32'h0000_0600, 32'h0, 4'h0, 0, 32'h600D_600D);
    ic_burst(32'h0000_5000, -1, 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared backing-memory port between the instruction-cache line refill path and the data-memory access path of the pipelined RISC-V core. It sits between the core/cache boundary and the external memory. It sequences multi-beat I-cache refill bursts and single-word data loads and stores. It also produces the `ic_repl_permit_o` strobe that the hazard unit consumes.

## Interface
- `BLOCK_WORDS`, default 4: words per I-cache line. Must be a power of two and ≥ 2.
- `clk_i` input 1: single clock. Everything is on the rising edge.
- `reset_i` input 1: reset, synchronous, active-high.
- `ic_req_i` input 1: I-cache refill request. Held until `ic_repl_permit_o` is seen.
- `ic_addr_i` input 32: miss address. Low `log2(BLOCK_WORDS)+2` bits are ignored.
- `ic_rvalid_o` output 1: one refill beat is valid this cycle.
- `ic_rdata_o` output 32: refill beat data.
- `ic_beat_o` output log2(BLOCK_WORDS): word index of the current beat.
- `ic_repl_permit_o` output 1: one-cycle strobe. The line is complete and the cache may commit the replacement.
- `dm_req_i` input 1: data access request. Held until `dm_done_o` is seen.
- `dm_we_i` input 1: 1 = store, 0 = load.
- `dm_addr_i` input 32: word address. Bits [1:0] are ignored.
- `dm_wdata_i` input 32: store data.
- `dm_byte_en_i` input 4: store byte enables.
- `dm_done_o` output 1: one-cycle completion strobe.
- `dm_rdata_o` output 32: load data, valid while `dm_done_o`=1.
- `mem_req_o` output 1: memory request, held until acknowledged.
- `mem_we_o` output 1: write enable.
- `mem_addr_o` output 32: word-aligned address.
- `mem_wdata_o` output 32: write data.
- `mem_byte_en_o` output 4: byte enables. All 1s for reads.
- `mem_ack_i` input 1: beat accepted. For reads, `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` input 32: read data.

## Operation
- States:
  - IDLE: no access in progress.
  - IC_BURST: I-cache refill burst in progress.
  - DM_ACCESS: single data access in progress.
  - IC_RESP: one-cycle I-cache completion.
  - DM_RESP: one-cycle data completion.
- Requests are sampled only in IDLE. A request that is high in any other state is ignored until the next IDLE cycle.
- Grant rules, in IDLE:
  - Only `dm_req_i` high → DM_ACCESS.
  - Only `ic_req_i` high → IC_BURST.
  - Both high → grant the requester not granted most recently.
- `last_grant` register:
  - Resets to I, so D wins the first tie.
  - Updated on every grant.
- At grant:
  - Latch the line base address (`ic_addr_i` with offset bits cleared), or
  - latch `dm_addr_i`, `dm_we_i`, `dm_wdata_i` and `dm_byte_en_i`.
  - Changes on these inputs after grant have no effect.
- IC_BURST:
  - `mem_req_o`=1 and `mem_we_o`=0.
  - `mem_addr_o` = line base + 4·`beat_cnt`.
  - `ic_rvalid_o` = `mem_ack_i`; `ic_rdata_o` = `mem_rdata_i`; `ic_beat_o` = `beat_cnt`.
  - `beat_cnt` increments on each ack.
  - Ack on beat `BLOCK_WORDS-1` → IC_RESP. `beat_cnt` wraps to 0.
- DM_ACCESS:
  - `mem_req_o`=1; `mem_we_o`, `mem_wdata_o` and `mem_byte_en_o` come from the latched values.
  - Loads drive `mem_byte_en_o`=4'hF.
  - On ack, `mem_rdata_i` is captured into `dm_rdata_o` and the state moves to DM_RESP.
- IC_RESP: `ic_repl_permit_o`=1 for exactly one cycle, then IDLE.
- DM_RESP: `dm_done_o`=1 for exactly one cycle. `dm_rdata_o` is held until the next load completes. Then IDLE.
- Bursts are never interrupted. A data request arriving mid-burst waits for IDLE.
- A requester must deassert its request in the RESP cycle. Otherwise it is re-granted as a new transaction.
- `mem_ack_i` is ignored outside IC_BURST and DM_ACCESS.
- Reset, including mid-burst:
  - State → IDLE, `beat_cnt` → 0, `last_grant` → I.
  - All outputs 0, including `dm_rdata_o`.
  - The partial line is never permitted: no `ic_repl_permit_o`.

## Timing
- Outputs are decoded from registered state and latched fields. Exceptions: `ic_rvalid_o` and `ic_rdata_o` follow `mem_ack_i` and `mem_rdata_i` combinationally.
- Data access, request first seen in IDLE at cycle t:
  - `mem_req_o` is high from t+1.
  - Ack at t+1+k gives `dm_done_o` at t+2+k.
  - The arbiter is back in IDLE at t+3+k.
- Refill burst, request first seen in IDLE at cycle t, ack every cycle:
  - Beats at t+1 … t+BLOCK_WORDS.
  - `ic_repl_permit_o` at t+BLOCK_WORDS+1.
- Memory wait states: stalled beats keep the address and `mem_req_o` stable until acked.

## Test plan
- Load, 2 wait states: `dm_req_i`=1, addr 0x100, memory acks 0xDEADBEEF on the 3rd request cycle. Expect `dm_done_o` one cycle later with `dm_rdata_o`=0xDEADBEEF, `mem_byte_en_o`=4'hF.
- Store: addr 0x204, data 0x12345678, byte_en 4'b0011. Expect `mem_we_o`=1 and `mem_addr_o`=0x204 with those data and enables; `dm_done_o` one cycle after ack.
- Refill, BLOCK_WORDS=4: `ic_addr_i`=0x1238, ack every cycle.
  - Expect addresses 0x1230, 0x1234, 0x1238, 0x123C.
  - Expect `ic_beat_o` 0,1,2,3 with `ic_rvalid_o`=1 on each.
  - Expect `ic_repl_permit_o`=1 for 1 cycle on the next cycle.
- Both requests in the same IDLE cycle twice in a row:
  - First grant: D.
  - Second grant: I.
  - No data request is served during the burst.
- Data request raised mid-burst: D is granted only after IC_RESP. It completes with correct data.
- `reset_i` pulsed after beat 1 of a burst:
  - All outputs 0 and no `ic_repl_permit_o`.
  - After reset, a simultaneous request pair grants D first.
